// File: rtl/key_mode_ctrl.sv
// Panel button front end: synchronise and debounce MODE/SET/HOUR/MIN, run the display
// mode FSM, and produce time-set pulses (with auto-repeat) and stopwatch controls.
module key_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_set,
    input  logic       key_hour,
    input  logic       key_min,
    output logic [1:0] tube_for,
    output logic       is_manual_set,
    output logic       sw_hour,
    output logic       sw_min,
    output logic       stopwatch_run,
    output logic       stopwatch_clear
);
    typedef enum logic [1:0] {ST_CLOCK = 2'd0, ST_SW = 2'd1, ST_ALARM = 2'd2} mode_e;

    localparam int K_MODE = 0;
    localparam int K_SET  = 1;
    localparam int K_HOUR = 2;
    localparam int K_MIN  = 3;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [3:0]            keys_raw;
    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            deb_q, deb_d, deb_dly_q, press;
    logic [3:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

    mode_e mode_q, mode_d;
    logic  manual_q, manual_d, run_q, run_d, clr_q, clr_d, hour_q, hour_d, min_q, min_d;
    logic  set_en, set_en_nxt;

    // Index 0 = HOUR, 1 = MIN
    logic [1:0]            rpt_act_q, rpt_act_d, rpt_first_q, rpt_first_d, fire;
    logic [1:0][CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    assign keys_raw = {key_min, key_hour, key_set, key_mode};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
                else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Combinational press strobe so registered outputs land DEBOUNCE_CYCLES+3 edges after the key
    assign press = deb_q & ~deb_dly_q;

    assign set_en = ((mode_q == ST_CLOCK) && manual_q) || (mode_q == ST_ALARM);

    always_comb begin
        mode_d   = mode_q;
        manual_d = manual_q;
        run_d    = run_q;
        clr_d    = 1'b0;
        case (mode_q)
            ST_CLOCK: if (press[K_SET]) manual_d = ~manual_q;
            ST_SW: begin
                if (press[K_HOUR]) run_d = ~run_q;
                if (press[K_MIN]) begin
                    clr_d = 1'b1;
                    run_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (press[K_MODE]) begin
            manual_d = 1'b0;
            case (mode_q)
                ST_CLOCK: mode_d = ST_SW;
                ST_SW:    mode_d = ST_ALARM;
                default:  mode_d = ST_CLOCK;
            endcase
        end
    end

    assign set_en_nxt = ((mode_d == ST_CLOCK) && manual_d) || (mode_d == ST_ALARM);

    always_comb begin
        for (int j = 0; j < 2; j++) begin
            rpt_act_d[j]   = rpt_act_q[j];
            rpt_first_d[j] = rpt_first_q[j];
            rpt_cnt_d[j]   = rpt_cnt_q[j];
            fire[j]        = 1'b0;
            if (set_en) begin
                if (press[j+2]) begin
                    fire[j]        = 1'b1;
                    rpt_act_d[j]   = 1'b1;
                    rpt_first_d[j] = 1'b1;
                    rpt_cnt_d[j]   = '0;
                end else if (rpt_act_q[j] && deb_q[j+2]) begin
                    if (rpt_cnt_q[j] == (rpt_first_q[j] ? RD_LAST : RP_LAST)) begin
                        fire[j]        = 1'b1;
                        rpt_first_d[j] = 1'b0;
                        rpt_cnt_d[j]   = '0;
                    end else begin
                        rpt_cnt_d[j] = rpt_cnt_q[j] + 1'b1;
                    end
                end else if (!deb_q[j+2]) begin
                    rpt_act_d[j] = 1'b0;
                    rpt_cnt_d[j] = '0;
                end
            end
            // A held key must be re-pressed after any mode change or loss of set enable
            if (!set_en || !set_en_nxt || press[K_MODE]) begin
                rpt_act_d[j]   = 1'b0;
                rpt_first_d[j] = 1'b0;
                rpt_cnt_d[j]   = '0;
            end
        end
        hour_d = fire[0];
        min_d  = fire[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_dly_q   <= '0;
            db_cnt_q    <= '0;
            mode_q      <= ST_CLOCK;
            manual_q    <= 1'b0;
            run_q       <= 1'b0;
            clr_q       <= 1'b0;
            hour_q      <= 1'b0;
            min_q       <= 1'b0;
            rpt_act_q   <= '0;
            rpt_first_q <= '0;
            rpt_cnt_q   <= '0;
        end else begin
            sync1_q     <= keys_raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_dly_q   <= deb_q;
            db_cnt_q    <= db_cnt_d;
            mode_q      <= mode_d;
            manual_q    <= manual_d;
            run_q       <= run_d;
            clr_q       <= clr_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            rpt_act_q   <= rpt_act_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    assign tube_for        = mode_q;
    assign is_manual_set   = manual_q;
    assign sw_hour         = hour_q;
    assign sw_min          = min_q;
    assign stopwatch_run   = run_q;
    assign stopwatch_clear = clr_q;
endmodule
